// File: rtl/noc_depacketizer_if.sv
// noc_depacketizer_if: flit ingress and reassembled-word egress bundle for the depacketizer
interface noc_depacketizer_if #(
  parameter int FLIT_WIDTH = 150,
  parameter int MAX_FLITS = 4,
  parameter int CNT_W = $clog2(MAX_FLITS + 1)
);
  logic flit_valid;
  logic flit_ready;
  logic flit_head;
  logic flit_tail;
  logic [FLIT_WIDTH-1:0] flit_data;
  logic out_valid;
  logic out_ready;
  logic [FLIT_WIDTH*MAX_FLITS-1:0] out_data;
  logic [CNT_W-1:0] out_nflits;
  logic out_trunc;
  logic err_pulse;
  logic [7:0] err_count;
  modport master (
    output flit_valid, flit_head, flit_tail, flit_data, out_ready,
    input flit_ready, out_valid, out_data, out_nflits, out_trunc, err_pulse, err_count
  );
  modport slave (
    input flit_valid, flit_head, flit_tail, flit_data, out_ready,
    output flit_ready, out_valid, out_data, out_nflits, out_trunc, err_pulse, err_count
  );
endinterface

// File: rtl/noc_depacketizer.sv
// noc_depacketizer: reassembles head/body/tail flits into one wide word per packet
module noc_depacketizer #(
  parameter int FLIT_WIDTH = 150,
  parameter int MAX_FLITS = 4,
  parameter int CNT_W = $clog2(MAX_FLITS + 1)
) (
  input logic clk_i,
  input logic rst_ni,
  noc_depacketizer_if.slave dp
);
  localparam int WW = FLIT_WIDTH * MAX_FLITS;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t state_q, state_d, eff;
  logic [WW-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic trunc_q, trunc_d;
  logic err_q, err_d;
  logic [7:0] errc_q, errc_d;
  logic xfer;
  logic full;
  assign dp.flit_ready = state_q != HOLD || dp.out_ready;
  assign xfer = dp.flit_valid && dp.flit_ready;
  assign full = cnt_q == CNT_W'(MAX_FLITS);
  // A word leaving HOLD this cycle frees the buffer, so the incoming flit is seen as arriving in IDLE
  assign eff = (state_q == HOLD && dp.out_ready) ? IDLE : state_q;
  always_comb begin
    state_d = eff;
    data_d = data_q;
    cnt_d = cnt_q;
    trunc_d = trunc_q;
    err_d = 1'b0;
    if (xfer && dp.flit_head) begin
      err_d = eff == COLLECT;
      data_d = WW'(dp.flit_data);
      cnt_d = CNT_W'(1);
      trunc_d = 1'b0;
      state_d = dp.flit_tail ? HOLD : COLLECT;
    end else if (xfer && eff == COLLECT) begin
      for (int k = 0; k < MAX_FLITS; k++)
        if (cnt_q == CNT_W'(k)) data_d[k*FLIT_WIDTH +: FLIT_WIDTH] = dp.flit_data;
      cnt_d = full ? cnt_q : cnt_q + CNT_W'(1);
      trunc_d = trunc_q || full;
      state_d = dp.flit_tail ? HOLD : COLLECT;
    end else if (xfer) begin
      err_d = 1'b1;
    end
    errc_d = (err_d && errc_q != 8'hFF) ? errc_q + 8'd1 : errc_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q <= '0;
      cnt_q <= '0;
      trunc_q <= 1'b0;
      err_q <= 1'b0;
      errc_q <= 8'd0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      trunc_q <= trunc_d;
      err_q <= err_d;
      errc_q <= errc_d;
    end
  end
  assign dp.out_valid = state_q == HOLD;
  assign dp.out_data = data_q;
  assign dp.out_nflits = cnt_q;
  assign dp.out_trunc = trunc_q;
  assign dp.err_pulse = err_q;
  assign dp.err_count = errc_q;
endmodule

// File: tb/tb_noc_depacketizer.sv
// tb_noc_depacketizer: directed self-checking bench for noc_depacketizer
module tb_noc_depacketizer;
  localparam int FW = 150;
  localparam int MF = 4;
  localparam int WW = FW * MF;
  logic clk;
  logic rst_n;
  int tests;
  int fails;
  noc_depacketizer_if #(.FLIT_WIDTH(FW), .MAX_FLITS(MF)) bus ();
  noc_depacketizer #(.FLIT_WIDTH(FW), .MAX_FLITS(MF)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .dp(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic flit(input logic h, input logic t, input logic [FW-1:0] d);
    bus.flit_valid = 1'b1;
    bus.flit_head = h;
    bus.flit_tail = t;
    bus.flit_data = d;
    @(posedge clk);
    #1;
    bus.flit_valid = 1'b0;
    bus.flit_head = 1'b0;
    bus.flit_tail = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_nflits !== 3'd0 || bus.out_trunc !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got v=%0b n=%0d t=%0b", bus.out_valid, bus.out_nflits, bus.out_trunc);
    end
    tests++;
    if (bus.err_pulse !== 1'b0 || bus.err_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_err got p=%0b c=%0d want 0 0", bus.err_pulse, bus.err_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.flit_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %0b want 1", bus.flit_ready);
    end
  endtask
  task automatic test_single;
    logic [WW-1:0] exp;
    exp = '0;
    exp[FW-1:0] = 150'hA5;
    bus.out_ready = 1'b1;
    flit(1'b1, 1'b1, 150'hA5);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
      fails++;
      $display("FAIL single_word got v=%0b d=%h want 1 %h", bus.out_valid, bus.out_data, exp);
    end
    tests++;
    if (bus.out_nflits !== 3'd1 || bus.out_trunc !== 1'b0) begin
      fails++;
      $display("FAIL single_meta got n=%0d t=%0b want 1 0", bus.out_nflits, bus.out_trunc);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain got %0b want 0", bus.out_valid);
    end
  endtask
  task automatic test_four;
    logic [WW-1:0] exp;
    exp = '0;
    for (int k = 0; k < 4; k++) exp[k*FW +: FW] = FW'(k + 1);
    bus.out_ready = 1'b0;
    flit(1'b1, 1'b0, 150'd1);
    flit(1'b0, 1'b0, 150'd2);
    flit(1'b0, 1'b0, 150'd3);
    flit(1'b0, 1'b1, 150'd4);
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.out_nflits !== 3'd4) begin
        fails++;
        $display("FAIL four_hold c%0d got v=%0b n=%0d d=%h want 1 4 %h", c, bus.out_valid, bus.out_nflits, bus.out_data, exp);
      end
      tests++;
      if (bus.flit_ready !== 1'b0) begin
        fails++;
        $display("FAIL four_ready_low c%0d got %0b want 0", c, bus.flit_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.flit_ready !== 1'b1) begin
      fails++;
      $display("FAIL four_ready_rise got %0b want 1", bus.flit_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL four_drain got %0b want 0", bus.out_valid);
    end
  endtask
  task automatic test_oversize;
    logic [WW-1:0] exp;
    exp = '0;
    for (int k = 0; k < 4; k++) exp[k*FW +: FW] = FW'(k + 10);
    bus.out_ready = 1'b0;
    flit(1'b1, 1'b0, 150'd10);
    for (int k = 11; k < 15; k++) flit(1'b0, 1'b0, FW'(k));
    flit(1'b0, 1'b1, 150'd15);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
      fails++;
      $display("FAIL oversize_data got v=%0b d=%h want 1 %h", bus.out_valid, bus.out_data, exp);
    end
    tests++;
    if (bus.out_nflits !== 3'd4 || bus.out_trunc !== 1'b1 || bus.err_count !== 8'd0) begin
      fails++;
      $display("FAIL oversize_meta got n=%0d t=%0b e=%0d want 4 1 0", bus.out_nflits, bus.out_trunc, bus.err_count);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_back_to_back;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.flit_valid = 1'b1;
      bus.flit_head = 1'b1;
      bus.flit_tail = 1'b1;
      bus.flit_data = FW'(i + 100);
      #1;
      tests++;
      if (bus.flit_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready i%0d got %0b want 1", i, bus.flit_ready);
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== WW'(i + 100) || bus.out_nflits !== 3'd1) begin
        fails++;
        $display("FAIL b2b_word i%0d got v=%0b n=%0d d=%h want 1 1 %0d", i, bus.out_valid, bus.out_nflits, bus.out_data, i + 100);
      end
    end
    bus.flit_valid = 1'b0;
    bus.flit_head = 1'b0;
    bus.flit_tail = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain got %0b want 0", bus.out_valid);
    end
  endtask
  task automatic test_errors;
    logic [WW-1:0] exp;
    exp = '0;
    exp[FW-1:0] = 150'd30;
    exp[FW +: FW] = 150'd31;
    bus.out_ready = 1'b1;
    flit(1'b0, 1'b0, 150'd7);
    tests++;
    if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'd1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL err_idle_body got p=%0b c=%0d v=%0b want 1 1 0", bus.err_pulse, bus.err_count, bus.out_valid);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.err_pulse !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse_width got %0b want 0", bus.err_pulse);
    end
    flit(1'b1, 1'b0, 150'd20);
    flit(1'b0, 1'b0, 150'd21);
    flit(1'b1, 1'b0, 150'd30);
    tests++;
    if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'd2) begin
      fails++;
      $display("FAIL err_mid_head got p=%0b c=%0d want 1 2", bus.err_pulse, bus.err_count);
    end
    flit(1'b0, 1'b1, 150'd31);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.out_nflits !== 3'd2 || bus.out_trunc !== 1'b0) begin
      fails++;
      $display("FAIL err_restart_word got v=%0b n=%0d d=%h want 1 2 %h", bus.out_valid, bus.out_nflits, bus.out_data, exp);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) flit(1'b0, 1'b0, FW'(i));
    tests++;
    if (bus.err_count !== 8'd255) begin
      fails++;
      $display("FAIL err_saturate got %0d want 255", bus.err_count);
    end
  endtask
  task automatic test_reset_mid;
    logic [WW-1:0] exp;
    exp = '0;
    exp[FW-1:0] = 150'd50;
    exp[FW +: FW] = 150'd51;
    bus.out_ready = 1'b1;
    flit(1'b1, 1'b0, 150'd40);
    flit(1'b0, 1'b0, 150'd41);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_nflits !== 3'd0 || bus.out_trunc !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== 8'd0) begin
      fails++;
      $display("FAIL rstmid_zero got v=%0b n=%0d t=%0b p=%0b c=%0d", bus.out_valid, bus.out_nflits, bus.out_trunc, bus.err_pulse, bus.err_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    flit(1'b1, 1'b0, 150'd50);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_early got %0b want 0", bus.out_valid);
    end
    flit(1'b0, 1'b1, 150'd51);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.out_nflits !== 3'd2 || bus.err_count !== 8'd0) begin
      fails++;
      $display("FAIL rstmid_word got v=%0b n=%0d c=%0d d=%h want 1 2 0 %h", bus.out_valid, bus.out_nflits, bus.err_count, bus.out_data, exp);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    tests = 0;
    fails = 0;
    bus.flit_valid = 1'b0;
    bus.flit_head = 1'b0;
    bus.flit_tail = 1'b0;
    bus.flit_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_four();
    test_oversize();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
